fir_par2_stream_ctrl: RTL and testbench

Stream controller for the L=2 polyphase FIR datapath `fir_parallel_2`. It sits between a one-sample-per-beat valid/ready source and the filter core:
- packs input samples into even/odd pairs and issues one block per `blk_en`;
- tracks the core's fixed pipeline latency and buffers result pairs in a small block FIFO;
- serializes the results back to a one-sample-per-beat valid/ready sink;
- injects zero blocks on request to flush the filter tail.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_blk_fifo.sv | 47 ++++
 rtl/fir_par2_stream_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fir_par2_stream_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the polyphase FIR stream controllers.
//   FIR_DW / FIR_OW : default input / output sample widths
//   fir_state_e     : input packing state (ST_EVEN / ST_ODD / ST_FLUSH)
package fir_pkg;

  localparam int FIR_DW = 16;
  localparam int FIR_OW = 32;

  typedef enum logic [1:0] {
    ST_EVEN  = 2'd0,
    ST_ODD   = 2'd1,
    ST_FLUSH = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_blk_fifo.sv
// Synchronous block FIFO holding {y1, y0} result pairs.
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : write wr_data at the tail
//   rd_en      : pop the head entry (caller only pops when non-empty)
//   rd_data    : head entry (combinational read)
//   empty/full : status from pointers carrying an extra wrap bit
module fir_blk_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_comb begin
    rd_data = mem[rd_ptr[AW-1:0]];
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  end

endmodule

// File: rtl/fir_par2_stream_ctrl.sv
// Stream controller for the L=2 polyphase FIR datapath.
//   s_valid/s_ready/s_data : one-sample-per-beat input stream
//   flush                  : one-cycle request to append FLUSH_BLKS zero blocks
//   blk_en/blk_x0/blk_x1   : block issue to the datapath (x0 older, x1 newer)
//   blk_y0/blk_y1          : datapath results, valid LAT cycles after blk_en
//   m_valid/m_ready/m_data : one-sample-per-beat output stream (y0 then y1)
//   busy                   : flush active, block in flight or FIFO non-empty
module fir_par2_stream_ctrl
  import fir_pkg::*;
#(
  parameter int DW         = FIR_DW,
  parameter int OW         = FIR_OW,
  parameter int LAT        = 3,
  parameter int OBUF_BLKS  = 4,
  parameter int FLUSH_BLKS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 flush,
  output logic                 blk_en,
  output logic signed [DW-1:0] blk_x0,
  output logic signed [DW-1:0] blk_x1,
  input  logic signed [OW-1:0] blk_y0,
  input  logic signed [OW-1:0] blk_y1,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic                 busy
);

  localparam int FCW = $clog2(FLUSH_BLKS + 1);
  localparam int OCW = $clog2(OBUF_BLKS) + 1;

  fir_state_e      state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   x0_q, x0_d;
  logic [OCW-1:0]  occ;
  logic [LAT-1:0]  en_sr;
  logic            phase;

  logic            credit_ok;
  logic            flush_req;
  logic            arrival;
  logic            fifo_wr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            m_hs;
  logic            pop;
  logic [2*OW-1:0] head;

  assign credit_ok = (occ < OCW'(OBUF_BLKS));
  assign flush_req = flush | pend_q;

  // Input packing FSM: next state and block issue
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    x0_d    = x0_q;
    s_ready = 1'b0;
    blk_en  = 1'b0;
    blk_x0  = '0;
    blk_x1  = '0;
    if (!reset) begin
      case (state_q)
        ST_EVEN: begin
          s_ready = 1'b1;
          if (s_valid) begin
            // A flush arriving with an accepted even sample is carried into
            // ST_ODD so the sample is padded and issued rather than dropped.
            x0_d    = s_data;
            state_d = ST_ODD;
            if (flush) pend_d = 1'b1;
          end else if (flush) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCW'(FLUSH_BLKS);
          end
        end
        ST_ODD: begin
          if (flush_req) begin
            if (credit_ok) begin
              blk_en  = 1'b1;
              blk_x0  = x0_q;
              state_d = ST_FLUSH;
              fcnt_d  = FCW'(FLUSH_BLKS);
              pend_d  = 1'b0;
            end else begin
              pend_d = 1'b1;
            end
          end else begin
            s_ready = credit_ok;
            if (s_valid && credit_ok) begin
              blk_en  = 1'b1;
              blk_x0  = x0_q;
              blk_x1  = s_data;
              state_d = ST_EVEN;
            end
          end
        end
        ST_FLUSH: begin
          if (credit_ok) begin
            blk_en = 1'b1;
            fcnt_d = fcnt_q - FCW'(1);
            if (fcnt_q == FCW'(1)) state_d = ST_EVEN;
          end
        end
        default: begin
          state_d = ST_EVEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EVEN;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      x0_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      x0_q    <= x0_d;
    end
  end

  // Arrival tracking: bit k set means a block was issued k+1 cycles ago
  always_ff @(posedge clk) begin
    if (reset) begin
      en_sr <= '0;
    end else begin
      en_sr <= (en_sr << 1) | LAT'(blk_en);
    end
  end

  assign arrival = en_sr[LAT-1];
  // Credit accounting makes overflow impossible; the guard only keeps a
  // corrupted pointer state from being made worse.
  assign fifo_wr = arrival & ~fifo_full;

  fir_blk_fifo #(
    .W     (2 * OW),
    .DEPTH (OBUF_BLKS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data ({blk_y1, blk_y0}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Output serializer
  assign m_valid = ~fifo_empty & ~reset;
  assign m_hs    = m_valid & m_ready;
  assign pop     = m_hs & phase;

  always_comb begin
    m_data = '0;
    if (m_valid) m_data = phase ? head[2*OW-1:OW] : head[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      occ   <= '0;
    end else begin
      if (m_hs) phase <= ~phase;
      case ({blk_en, pop})
        2'b10:   occ <= occ + OCW'(1);
        2'b01:   occ <= occ - OCW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign busy = ~reset & ((state_q == ST_FLUSH) | pend_q | (occ != '0) | ~fifo_empty);

endmodule

// File: tb/tb_fir_par2_stream_ctrl.sv
module tb_fir_par2_stream_ctrl;

  localparam int DW  = 16;
  localparam int OW  = 32;
  localparam int LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 flush;
  logic                 blk_en;
  logic signed [DW-1:0] blk_x0;
  logic signed [DW-1:0] blk_x1;
  logic signed [OW-1:0] blk_y0;
  logic signed [OW-1:0] blk_y1;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  logic signed [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fir_par2_stream_ctrl #(
    .DW         (DW),
    .OW         (OW),
    .LAT        (LAT),
    .OBUF_BLKS  (4),
    .FLUSH_BLKS (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .flush   (flush),
    .blk_en  (blk_en),
    .blk_x0  (blk_x0),
    .blk_x1  (blk_x1),
    .blk_y0  (blk_y0),
    .blk_y1  (blk_y1),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy)
  );

  function automatic logic signed [OW-1:0] sext(input logic [DW-1:0] d);
    return {{(OW-DW){d[DW-1]}}, d};
  endfunction

  // Identity mock datapath: three register stages
  logic signed [OW-1:0] p0a, p0b, p0c, p1a, p1b, p1c;
  always @(posedge clk) begin
    if (reset) begin
      p0a <= '0; p0b <= '0; p0c <= '0;
      p1a <= '0; p1b <= '0; p1c <= '0;
    end else begin
      p0a <= sext(blk_x0); p0b <= p0a; p0c <= p0b;
      p1a <= sext(blk_x1); p1b <= p1a; p1c <= p1b;
    end
  end
  assign blk_y0 = p0c;
  assign blk_y1 = p1c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and invariant monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (s_valid && s_ready) exp_q.push_back(sext(s_data));
      if (m_valid && m_ready) begin
        out_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0d expected none at %0t", m_data, $time);
        end else begin
          logic signed [OW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL sb_data: got %0d expected %0d at %0t", m_data, e, $time);
          end
        end
      end
      if (int'(dut.occ) > 4) begin
        errors++;
        $display("FAIL occ_bound: got %0d expected <=4 at %0t", dut.occ, $time);
      end
      if (dut.arrival && dut.fifo_full) begin
        errors++;
        $display("FAIL fifo_overflow: got write-when-full expected none at %0t", $time);
      end
    end
  end

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        fl;
    logic        mr;
    logic        e_sr;
    logic        e_en;
    logic [15:0] e_x0;
    logic [15:0] e_x1;
    logic        e_mv;
    logic [31:0] e_md;
  } vec_t;

  vec_t tbl[10];

  task automatic run_impulse(input string tag);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s_valid = tbl[i].sv; s_data = tbl[i].sd; flush = tbl[i].fl; m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("%s%0d_s_ready", tag, i), s_ready, tbl[i].e_sr);
      chk($sformatf("%s%0d_blk_en", tag, i), blk_en, tbl[i].e_en);
      chk($sformatf("%s%0d_blk_x0", tag, i), blk_x0, tbl[i].e_x0);
      chk($sformatf("%s%0d_blk_x1", tag, i), blk_x1, tbl[i].e_x1);
      chk($sformatf("%s%0d_m_valid", tag, i), m_valid, tbl[i].e_mv);
      chk($sformatf("%s%0d_m_data", tag, i), m_data, tbl[i].e_md);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output int ens, output bit ok);
    ens = 0;
    ok  = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      if (blk_en) ens++;
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int  ens;
  bit  ok;
  int  idx;
  int  acc;
  int  base;

  initial begin
    // sv sd fl mr | s_ready blk_en x0 x1 m_valid m_data
    tbl[0] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 16'd0, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 32'd0};
    tbl[4] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 32'd1};
    tbl[6] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 32'd0};
    tbl[7] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 32'd0};
    tbl[8] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 32'd0};
    tbl[9] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_blk_en", blk_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m_data", m_data, 0);
    chk("post_rst_busy", busy, 0);

    run_impulse("imp");

    // Flush from ST_ODD: (5,0) then 8 zero blocks
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'sd5; m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_blk_en", blk_en, 1);
    chk("fl_blk_x0", blk_x0, 5);
    chk("fl_blk_x1", blk_x1, 0);
    repeat (17) exp_q.push_back('0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_busy_high", busy, 1);
    ens = blk_en ? 1 : 0;
    begin
      int more;
      drain(100, more, ok);
      ens += more;
    end
    chk("fl_drain_done", ok, 1);
    chk("fl_zero_blocks", ens, 8);
    chk("fl_busy_low", busy, 0);

    // Same-cycle flush and input beat in ST_ODD
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'sd7;
    @(negedge clk);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'sd9; flush = 1'b1;
    @(negedge clk);
    chk("sc_s_ready", s_ready, 0);
    chk("sc_blk_en", blk_en, 1);
    chk("sc_blk_x0", blk_x0, 7);
    chk("sc_blk_x1", blk_x1, 0);
    repeat (17) exp_q.push_back('0);
    drain(100, ens, ok);
    chk("sc_drain_done", ok, 1);
    chk("sc_busy_low", busy, 0);

    // Reset with two blocks in flight
    for (int k = 3; k <= 6; k++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = DW'(k); m_ready = 1'b1; flush = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_blk_en", blk_en, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_m_data", m_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_blk_en_after", blk_en, 0);
    chk("mrst_s_ready_after", s_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mrst_no_stale_valid", m_valid, 0);
    end
    run_impulse("imp2_");

    // Backpressure: m_ready low while offering 1..20
    base = out_cnt;
    idx = 1; acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      m_ready = 1'b0; s_valid = 1'b1; s_data = DW'(idx);
      @(negedge clk);
      if (s_ready) begin idx++; acc++; end
    end
    chk("bp_accepted", acc, 9);
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_occ", dut.occ, 4);
    chk("bp_m_valid", m_valid, 1);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      m_ready = 1'b1; s_valid = (idx <= 20); s_data = DW'(idx);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      if (idx > 20 && exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("bp_done", ok, 1);
    chk("bp_out_count", out_cnt - base, 20);

    // Output pacing: m_ready toggles every cycle
    base = out_cnt;
    idx = 1; ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      m_ready = c[0]; s_valid = (idx <= 16); s_data = DW'(-idx);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      if (idx > 16 && exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("pace_done", ok, 1);
    chk("pace_out_count", out_cnt - base, 16);

    s_valid = 1'b0; m_ready = 1'b0;
    chk("sb_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
